// File: rtl/divider_seq.sv
// divider_seq: sequential 8-bit by 4-bit unsigned restoring divider.
// Produces one quotient bit per clock, MSB first; 8 steps per division.
//
// Optional feature (compile-time): define DIV_ZERO_DETECT_EN to add the dbz
// output and a one-edge fast path for divisor == 0. Without it, a zero
// divisor runs the normal 8 steps and naturally yields quotient 8'hFF and
// remainder dividend[3:0].
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; results from the last operation held
// S_RUN  | one restoring step per edge, counter counts 8 down to 0
// S_DONE | done pulse for one cycle, then back to S_IDLE
module divider_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic       busy,
    output logic       done,
    output logic [7:0] quotient,
    output logic [3:0] remainder
`ifdef DIV_ZERO_DETECT_EN
    ,
    output logic       dbz
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'd8;
    localparam logic [3:0] CNT_LAST = 4'd1;

    state_t     state_q, state_d;

    // Shared shift register: dividend bits leave at the top while quotient
    // bits enter at the bottom, so after 8 steps it holds the quotient.
    logic [7:0] work_q, work_d;
    logic [3:0] dvs_q, dvs_d;
    logic [4:0] prem_q, prem_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] quotient_q, quotient_d;
    logic [3:0] remainder_q, remainder_d;

    logic [5:0] prem_wide;
    logic       prem_ge;
    logic [4:0] prem_next;
    logic [7:0] work_next;
    logic       last_step;
    logic       zero_fast;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_fast = (divisor == 4'd0);
`else
    assign zero_fast = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit, trial-subtract,
    // keep the difference only when it does not go negative.
    always_comb begin
        prem_wide = {prem_q, work_q[7]};
        prem_ge   = (prem_wide >= {2'b00, dvs_q});
        // For any nonzero divisor the kept remainder is below 16, so the
        // 5-bit truncation only matters for divisor 0, where it leaves the
        // low dividend bits and thus remainder == dividend[3:0].
        if (prem_ge) begin
            prem_next = 5'(prem_wide - {2'b00, dvs_q});
        end else begin
            prem_next = prem_wide[4:0];
        end
        work_next = {work_q[6:0], prem_ge};
        last_step = (cnt_q == CNT_LAST);
    end

    // Next-state and datapath control for the three-state sequencer.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = dividend;
                    dvs_d  = divisor;
                    prem_d = 5'd0;
                    if (zero_fast) begin
                        // Skip the iterations; the result is known up front.
                        state_d     = S_DONE;
                        cnt_d       = 4'd0;
                        quotient_d  = 8'hFF;
                        remainder_d = dividend[3:0];
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            S_RUN: begin
                work_d = work_next;
                prem_d = prem_next;
                cnt_d  = cnt_q - 4'd1;
                if (last_step) begin
                    state_d     = S_DONE;
                    quotient_d  = work_next;
                    remainder_d = prem_next[3:0];
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= 8'd0;
            dvs_q       <= 4'd0;
            prem_q      <= 5'd0;
            cnt_q       <= 4'd0;
            quotient_q  <= 8'd0;
            remainder_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    logic dbz_q, dbz_d;

    // Divide-by-zero flag: set or cleared only when a start is accepted.
    always_comb begin
        dbz_d = dbz_q;
        if ((state_q == S_IDLE) && start) begin
            dbz_d = zero_fast;
        end
    end

    // Divide-by-zero flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbz_q <= 1'b0;
        end else begin
            dbz_q <= dbz_d;
        end
    end

    assign dbz = dbz_q;
`endif

    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: the driver pushes expected results
// computed with plain / and %, and a negedge monitor compares whenever done
// is expected or seen, plus held outputs and busy every cycle.
module tb_divider_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = 8'd0;
    logic [3:0] divisor = 4'd0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
`ifdef DIV_ZERO_DETECT_EN
    logic       dbz;
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    divider_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_DETECT_EN
        ,
        .dbz       (dbz)
`endif
    );

    typedef struct {
        int unsigned due;
        logic [7:0]  q;
        logic [3:0]  r;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int unsigned busy_lo = 1;
    int unsigned busy_hi = 0;
    logic [7:0]  hold_q = 8'd0;
    logic [3:0]  hold_r = 4'd0;
    logic        hold_dbz = 1'b0;
    bit          mon_exp_done;
    bit          mon_exp_busy;
    exp_t        mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        mon_exp_done = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        checks++;
        if (done !== mon_exp_done) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, mon_exp_done);
        end
        if (mon_exp_done) begin
            mon_e  = exp_q.pop_front();
            hold_q = mon_e.q;
            hold_r = mon_e.r;
        end
        checks++;
        if (quotient !== hold_q) begin
            errors++;
            $display("FAIL quotient cyc=%0d got=%0d exp=%0d", cyc, quotient, hold_q);
        end
        checks++;
        if (remainder !== hold_r) begin
            errors++;
            $display("FAIL remainder cyc=%0d got=%0d exp=%0d", cyc, remainder, hold_r);
        end
        mon_exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        checks++;
        if (busy !== mon_exp_busy) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, mon_exp_busy);
        end
`ifdef DIV_ZERO_DETECT_EN
        checks++;
        if (dbz !== hold_dbz) begin
            errors++;
            $display("FAIL dbz cyc=%0d got=%b exp=%b", cyc, dbz, hold_dbz);
        end
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Issue one division; optionally pulse start with junk operands while
    // the operation is in flight, then idle for gap cycles.
    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input bit noise, input int gap);
        exp_t        e;
        int unsigned n;
        int          lat;
        bit          fast;
        step();
        n    = cyc;
        fast = FAST_ZERO && (b == 4'd0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        e.due = fast ? n + 1 : n + 9;
        e.q   = (b == 4'd0) ? 8'hFF : 8'(int'(a) / int'(b));
        e.r   = (b == 4'd0) ? a[3:0] : 4'(int'(a) % int'(b));
        exp_q.push_back(e);
        if (!fast) begin
            busy_lo = n + 1;
            busy_hi = n + 8;
        end
        hold_dbz = fast;
        lat = fast ? 2 : 10;
        for (int i = 1; i < lat; i++) begin
            step();
            start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            dividend = 8'($urandom);
            divisor  = 4'($urandom);
        end
        repeat (gap) begin
            step();
            start = 1'b0;
        end
    endtask

    // Start a division and reset it during its 4th RUN cycle.
    task automatic issue_abort(input logic [7:0] a, input logic [3:0] b);
        int unsigned n;
        step();
        n        = cyc;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        busy_lo  = n + 1;
        busy_hi  = n + 8;
        hold_dbz = 1'b0;
        while (cyc < n + 4) begin
            step();
            start    = 1'b0;
            dividend = 8'($urandom);
        end
        rst      = 1'b1;
        busy_hi  = n + 4;
        hold_q   = 8'd0;
        hold_r   = 4'd0;
        hold_dbz = 1'b0;
        exp_q.delete();
        step();
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        rst = 1'b0;

        issue(8'd200, 4'd7, 1'b0, 0);
        issue(8'd225, 4'd15, 1'b0, 2);
        issue(8'd5, 4'd9, 1'b0, 0);
        issue(8'd255, 4'd1, 1'b0, 1);
        issue(8'd0, 4'd15, 1'b0, 0);
        issue(8'h5A, 4'd6, 1'b1, 0);
        issue(8'd131, 4'd11, 1'b1, 3);
        issue_abort(8'd77, 4'd5);
        issue(8'd100, 4'd3, 1'b0, 0);
        issue(8'hA6, 4'd0, 1'b0, 1);
        issue(8'hA6, 4'd0, 1'b1, 0);
        issue(8'd200, 4'd7, 1'b0, 0);

        repeat (40) begin
            issue(8'($urandom), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        step();
        start = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
